fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 39 +++
 rtl/fetch_queue.sv | 71 +++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared architecture widths and response classification for the fetch queue
package fetch_queue_pkg;
  localparam int ARCH_ADDRESS_SIZE = 10;
  localparam int ARCH_INSTRUCTION_SIZE = 16;
  typedef enum logic [1:0] {RESP_NONE, RESP_PUSH, RESP_DROP, RESP_FLUSH} resp_e;
  function automatic resp_e resp_action(input logic jump, input logic valid, input logic dropping);
    return jump ? RESP_FLUSH : !valid ? RESP_NONE : dropping ? RESP_DROP : RESP_PUSH;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of {pc, instruction} entries with push, pop and flush
module fetch_fifo #(
  parameter int W = 26,
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q <= wr_q;
      count_q <= '0;
    end else begin
      rd_q <= rd_q + PW'(pop_i);
      wr_q <= wr_q + PW'(push_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  // empty queue presents zeros rather than a stale slot
  assign data_o = (count_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction prefetch with in-order responses, redirect drop and halt
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDRESS_SIZE = ARCH_ADDRESS_SIZE,
  parameter int INSTRUCTION_SIZE = ARCH_INSTRUCTION_SIZE,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        fetch_req,
  output logic [ADDRESS_SIZE-1:0]     fetch_pc,
  input  logic                        fetch_valid,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                        jump,
  input  logic [ADDRESS_SIZE-1:0]     jump_pc,
  input  logic                        halt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTRUCTION_SIZE-1:0] instruction_out,
  output logic [ADDRESS_SIZE-1:0]     instruction_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W = ADDRESS_SIZE + INSTRUCTION_SIZE;
  logic [ADDRESS_SIZE-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count;
  logic [CW:0] inflight;
  logic [W-1:0] head;
  logic issue, push, pop;
  resp_e resp;
  // queued plus in-flight entries never exceed DEPTH, so a response always has a slot
  assign inflight = {1'b0, count} + {1'b0, outst_q};
  assign issue = !reset && !halt && !jump && inflight < (CW+1)'(DEPTH) && outst_q < CW'(MAX_OUTSTANDING);
  assign resp = resp_action(jump, fetch_valid, drop_q != '0);
  assign push = !reset && resp == RESP_PUSH;
  assign pop = out_valid && out_ready && !jump;
  always_comb begin
    fetch_pc_d = jump ? jump_pc : fetch_pc_q + ADDRESS_SIZE'(issue);
    resp_pc_d = jump ? jump_pc : resp_pc_q + ADDRESS_SIZE'(push);
    outst_d = outst_q + CW'(issue) - CW'(fetch_valid);
    drop_d = jump ? outst_d : drop_q - CW'(resp == RESP_DROP);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= '0;
      resp_pc_q <= '0;
      outst_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q <= outst_d;
      drop_q <= drop_d;
    end
  end
  fetch_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clock),
    .rst(reset),
    .push_i(push),
    .pop_i(pop),
    .flush_i(jump),
    .data_i({resp_pc_q, instruction}),
    .data_o(head),
    .count_o(count)
  );
  assign fetch_req = issue;
  assign fetch_pc = fetch_pc_q;
  assign out_valid = !reset && count != '0;
  assign {instruction_pc, instruction_out} = reset ? '0 : head;
endmodule
